// File: rtl/pc_fetch_unit_pkg.sv
// Shared fetch-path encodings and the {pc, instruction} buffer entry type.
// Guarded macros so other units including the same encodings see one definition.
`ifndef PC_FETCH_UNIT_DEFINES
`define PC_FETCH_UNIT_DEFINES
`define FETCH_RESET_PC (32'h0000_0000)
`define INST_NOP       (32'h0000_0013)
`endif

package pc_fetch_unit_pkg;

    localparam logic [31:0] FETCH_RESET_PC = `FETCH_RESET_PC;
    localparam int          PC_W           = 32;
    localparam int          ENTRY_W        = 2 * PC_W;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [PC_W-1:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_fifo.sv
// Synchronous instruction buffer between fetch and decode; flush discards every entry.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count_q != '0) && !flush;
    assign do_push = push && !flush && ((count_q != (AW+1)'(DEPTH)) || do_pop);

    // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
    // NOTE: the data array is never reset; count gates validity, so only pointers need clearing.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Owns the architectural fetch PC, issues one-at-a-time imem requests and buffers
// {pc, instruction} pairs for decode; redirects flush wrong-path state.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = FETCH_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        misalign
);

    localparam int             CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        outstanding_q, outstanding_d;
    logic        discard_q, discard_d;
    logic        misalign_q, misalign_d;

    logic [CW-1:0]      fifo_count;
    logic [ENTRY_W-1:0] fifo_head;
    fetch_entry_t       head_entry;
    fetch_entry_t       push_entry;
    logic               req_fire;
    logic               rsp_fire;
    logic               fifo_push;
    logic               fifo_pop;

    // A redirect withdraws the request in the same cycle, so no accept can race it.
    assign imem_req_valid = !reset && !outstanding_q && (fifo_count < DEPTH_C)
                            && !misalign_q && !redirect_valid;
    assign imem_req_addr  = reset ? RESET_PC : fetch_pc_q;

    assign req_fire  = imem_req_valid && imem_req_ready;
    assign rsp_fire  = imem_rsp_valid && outstanding_q;
    assign fifo_push = rsp_fire && !discard_q && !redirect_valid;
    assign fifo_pop  = inst_valid && inst_ready;

    assign push_entry = '{pc: req_pc_q, inst: imem_rsp_data};
    assign head_entry = fetch_entry_t'(fifo_head);

    assign inst_valid = !reset && (fifo_count != '0);
    assign inst_pc    = reset ? '0 : head_entry.pc;
    assign inst_data  = reset ? '0 : head_entry.inst;
    assign misalign   = misalign_q;

    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        misalign_d    = misalign_q;

        if (redirect_valid) begin
            fetch_pc_d    = align_pc(redirect_pc);
            misalign_d    = is_misaligned(redirect_pc);
            outstanding_d = outstanding_q && !imem_rsp_valid;
            discard_d     = outstanding_q && !imem_rsp_valid;
        end else begin
            if (rsp_fire) begin
                outstanding_d = 1'b0;
                discard_d     = 1'b0;
            end
            if (req_fire) begin
                outstanding_d = 1'b1;
                req_pc_d      = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            req_pc_q      <= RESET_PC;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            misalign_q    <= misalign_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboarded bench for pc_fetch_unit: an in-order memory model answers requests, a path
// model predicts the instruction stream, and a monitor compares every delivered instruction.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        misalign;

    pc_fetch_unit #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .misalign       (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    mem_req_t    pend_q[$];
    exp_t        exp_q[$];
    int          acc_cyc_q[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] mem_key;
    logic [31:0] path_pc;
    logic [31:0] exp_req_addr;
    logic [31:0] last_deliv_pc = 32'hFFFF_FFFF;
    bit          misalign_exp = 1'b0;
    bit          redir_prev = 1'b0;
    int          mis_hold = 0;
    int          cyc = 0;
    int          acc_count = 0;
    int          total_deliv = 0;
    int          first_deliv_cyc = -1;

    // Stimulus knobs
    int          ready_pct = 100;
    int          inst_ready_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          rand_redirect_en = 1'b0;
    bit          rand_reset_en = 1'b0;
    bit          junk_en = 1'b0;
    bit          late_junk = 1'b0;
    bit          force_reset = 1'b0;
    bit          force_redirect = 1'b0;
    logic [31:0] force_target = 32'h0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ mem_key ^ {a[15:0], a[31:16]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // One clock of stimulus: inputs change on the falling edge, outputs are checked 1 unit later.
    task automatic step();
        bit          do_rst;
        bit          do_redir;
        bit          rsp_now;
        bit          junk;
        int          pend_before;
        int          r;
        logic [31:0] tgt;
        logic [31:0] rnd;

        @(negedge clk);
        cyc++;
        do_rst      = force_reset || (rand_reset_en && $urandom_range(599) == 0);
        pend_before = pend_q.size();
        rsp_now     = !do_rst && (pend_before > 0) && (pend_q[0].due <= cyc);
        junk        = !do_rst && (pend_before == 0) &&
                      (late_junk || (junk_en && $urandom_range(7) == 0));
        do_redir    = 1'b0;
        tgt         = 32'h0;
        if (!do_rst) begin
            if (force_redirect) begin
                do_redir = 1'b1;
                tgt      = force_target;
            end else if (rand_redirect_en) begin
                if (misalign_exp) do_redir = (mis_hold >= 20) && ($urandom_range(3) == 0);
                else              do_redir = ($urandom_range(rsp_now ? 7 : 39) == 0);
                r   = int'($urandom_range(15));
                rnd = $urandom;
                if (r == 0)                     tgt = 32'hFFFF_FFF0;
                else if (r < 3 && !misalign_exp) tgt = (rnd & 32'h0000_FFFC) | 32'(r);
                else                            tgt = rnd & 32'h0000_FFFC;
            end
        end

        rnd            = $urandom;
        reset          = do_rst;
        redirect_valid = do_redir;
        redirect_pc    = do_redir ? tgt : rnd;
        imem_rsp_valid = rsp_now || junk;
        imem_rsp_data  = rsp_now ? word_of(pend_q[0].addr) : ~rnd;
        imem_req_ready = ($urandom_range(99) < ready_pct);
        inst_ready     = ($urandom_range(99) < inst_ready_pct);
        if (rsp_now) void'(pend_q.pop_front());
        #1;

        if (do_rst) begin
            check("rst_req_valid", 32'(imem_req_valid), 32'd0);
            check("rst_inst_valid", 32'(inst_valid), 32'd0);
            check("rst_inst_data", inst_data, 32'd0);
            check("rst_inst_pc", inst_pc, 32'd0);
            check("rst_req_addr", imem_req_addr, RST_PC);
            pend_q.delete();
            exp_q.delete();
            path_pc      = RST_PC;
            exp_req_addr = RST_PC;
            misalign_exp = 1'b0;
            mis_hold     = 0;
            redir_prev   = 1'b0;
            cyc          = 0;
        end else begin
            if (redir_prev) check("flush_empty", 32'(inst_valid), 32'd0);
            if (redir_prev && !do_redir && pend_before == 0 && !misalign_exp)
                check("redir_issue", 32'(imem_req_valid), 32'd1);
            check("misalign", 32'(misalign), 32'(misalign_exp));
            if (misalign_exp) check("misalign_halt", 32'(imem_req_valid), 32'd0);
            if (imem_req_valid && imem_req_ready) begin
                check("one_outstanding", pend_before, 32'd0);
                check("req_addr", imem_req_addr, exp_req_addr);
                pend_q.push_back('{addr: exp_req_addr,
                                   due: cyc + int'($urandom_range(lat_max, lat_min))});
                exp_req_addr += 32'd4;
                acc_count++;
                acc_cyc_q.push_back(cyc);
            end
            if (do_redir) begin
                path_pc      = {tgt[31:2], 2'b00};
                exp_req_addr = path_pc;
                misalign_exp = (tgt[1:0] != 2'b00);
                mis_hold     = 0;
                exp_q.delete();
            end else if (misalign_exp) begin
                mis_hold++;
            end
            redir_prev = do_redir;
        end

        // Expected stream for the current path, extended ahead of consumption.
        if (!misalign_exp) begin
            while (exp_q.size() < 8) begin
                exp_q.push_back('{pc: path_pc, data: word_of(path_pc)});
                path_pc += 32'd4;
            end
        end
    endtask

    task automatic apply_reset();
        force_reset = 1'b1;
        repeat (3) step();
        force_reset = 1'b0;
        acc_count = 0;
        acc_cyc_q.delete();
        first_deliv_cyc = -1;
    endtask

    task automatic do_redirect(input logic [31:0] target);
        force_redirect = 1'b1;
        force_target   = target;
        step();
        force_redirect = 1'b0;
    endtask

    task automatic step_until_acc(input int n, input string name);
        int k = 0;
        while (acc_count < n && k < 50) begin
            step();
            k++;
        end
        check(name, acc_count, n);
    endtask

    // Monitor: compares each consumed head against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && !redirect_valid && inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_inst: got pc %h data %h, expected none", inst_pc, inst_data);
                end else begin
                    e = exp_q.pop_front();
                    check("inst_pc", inst_pc, e.pc);
                    check("inst_data", inst_data, e.data);
                end
                last_deliv_pc = inst_pc;
                total_deliv++;
                if (first_deliv_cyc < 0) first_deliv_cyc = cyc;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        mem_key        = $urandom;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        inst_ready     = 1'b0;

        // Steady stream with 1-cycle memory: requests on cycles 1, 3, 5; first inst on cycle 3.
        apply_reset();
        repeat (6) step();
        check("p1_acc_count", acc_count, 32'd3);
        for (int i = 0; i < 3; i++)
            check($sformatf("p1_acc_cyc%0d", i),
                  (i < acc_cyc_q.size()) ? acc_cyc_q[i] : -1, 2 * i + 1);
        check("p1_first_inst_cyc", first_deliv_cyc, 32'd3);

        // Backpressure: two entries fill the buffer and fetch stalls.
        apply_reset();
        inst_ready_pct = 0;
        repeat (10) step();
        check("p2_stall_acc", acc_count, 32'd2);
        check("p2_stall_req", 32'(imem_req_valid), 32'd0);
        check("p2_full_valid", 32'(inst_valid), 32'd1);
        inst_ready_pct = 100;
        repeat (10) step();
        check("p2_resumed", 32'(acc_count > 2), 32'd1);

        // Redirect while 0x8 is outstanding.
        apply_reset();
        lat_min = 3;
        lat_max = 3;
        step_until_acc(3, "p3_reach_0x8");
        do_redirect(32'h0000_0100);
        repeat (20) step();
        check("p3_new_path", 32'(last_deliv_pc[31:8] == 24'h1), 32'd1);

        // Redirect coinciding with the response for 0x4.
        apply_reset();
        lat_min = 1;
        lat_max = 1;
        step_until_acc(2, "p4_reach_0x4");
        do_redirect(32'h0000_0200);
        repeat (10) step();
        check("p4_new_path", 32'(last_deliv_pc[31:8] == 24'h2), 32'd1);

        // Misaligned redirect halts fetch until an aligned one.
        do_redirect(32'h0000_0102);
        repeat (20) step();
        check("p5_halted", 32'(misalign), 32'd1);
        do_redirect(32'h0000_0040);
        repeat (12) step();
        check("p5_recover", 32'(last_deliv_pc >= 32'h40 && last_deliv_pc < 32'h100), 32'd1);

        // Reset with one entry buffered and one request in flight; a late response is ignored.
        apply_reset();
        lat_min = 3;
        lat_max = 3;
        inst_ready_pct = 0;
        step_until_acc(2, "p6_fill");
        check("p6_buffered", 32'(inst_valid), 32'd1);
        force_reset = 1'b1;
        step();
        force_reset = 1'b0;
        acc_count = 0;
        acc_cyc_q.delete();
        ready_pct = 0;
        inst_ready_pct = 100;
        late_junk = 1'b1;
        step();
        late_junk = 1'b0;
        ready_pct = 100;
        step();
        check("p6_junk_ignored", 32'(inst_valid), 32'd0);
        repeat (12) step();
        check("p6_refetch", 32'(acc_count > 0), 32'd1);
        check("p6_restart", 32'(last_deliv_pc < 32'h40), 32'd1);

        // Randomized traffic: redirects (incl. wrap and misaligned), stray responses, resets.
        apply_reset();
        total_deliv      = 0;
        rand_redirect_en = 1'b1;
        rand_reset_en    = 1'b1;
        junk_en          = 1'b1;
        ready_pct        = 60;
        lat_min          = 1;
        lat_max          = 3;
        for (int blk = 0; blk < 6; blk++) begin
            inst_ready_pct = (blk % 3 == 0) ? 30 : ((blk % 3 == 1) ? 100 : 70);
            repeat (500) step();
        end
        check("rand_progress", 32'(total_deliv > 100), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Consumer side of the next-PC path: owns the architectural fetch PC register.
- Issues instruction-memory requests over a valid/ready handshake and takes in-order responses.
- Buffers fetched {pc, instruction} pairs in a small FIFO toward decode.
- Accepts redirects (branch/jump/jalr targets computed by next-PC logic), flushing any wrong-path state.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of 2, ≥2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- redirect_valid  in  1  one-cycle pulse: load redirect_pc as the new fetch PC.
- redirect_pc  in  32  redirect target.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  fetch address (word aligned).
- imem_rsp_valid  in  1  response valid; in order, ≥1 cycle after accept.
- imem_rsp_data  in  32  fetched instruction.
- inst_valid  out  1  FIFO head valid toward decode.
- inst_ready  in  1  decode consumes head.
- inst_data  out  32  head instruction.
- inst_pc  out  32  PC of head instruction.
- misalign  out  1  redirect target had bits[1:0]≠0; fetch halted.

Behaviour:
- Reset, while reset=1 at a clock edge:
  - fetch_pc=RESET_PC; FIFO emptied; outstanding=0; discard=0; misalign=0.
  - During reset cycles: imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0, imem_req_addr=RESET_PC.
- Outputs are combinational from registers only, except the same-cycle redirect gating below.
- Issue rule: imem_req_valid = !reset && !outstanding && count<FIFO_DEPTH && !misalign && !redirect_valid.
  - imem_req_addr = fetch_pc.
  - The first request is visible in the first cycle after reset deasserts.
- Request accept (valid && ready): outstanding←1, req_pc←fetch_pc, fetch_pc←fetch_pc+4 (mod 2^32, wraps 32'hFFFF_FFFC→0).
  - While not accepted, valid and addr stay stable unless a redirect occurs.
  - At most one outstanding request. With 1-cycle memory latency, steady throughput is 1 instruction per 2 cycles.
- Response (imem_rsp_valid while outstanding): outstanding←0.
  - If discard=0 and no redirect this cycle: push {req_pc, imem_rsp_data}.
  - Otherwise the response is dropped and discard←0.
  - imem_rsp_valid while outstanding=0 is ignored.
- Redirect, highest priority:
  - fetch_pc←{redirect_pc[31:2],2'b00}; FIFO flushed; any same-cycle push or pop ignored.
  - If a request is outstanding and its response is not arriving this cycle: discard←1.
  - Any unaccepted request is withdrawn (valid low this cycle). If memory accepted it in this same cycle, it counts as outstanding and is discarded.
  - misalign←(redirect_pc[1:0]≠0). While misalign=1, no requests issue; it clears only on an aligned redirect or reset.
  - inst_valid=0 in the cycle after the redirect. The first new-path request issues in that cycle if outstanding=0, otherwise once the discarded response returns.
- FIFO:
  - inst_valid = count≠0; inst_data/inst_pc come from the head.
  - Pop on inst_valid && inst_ready. Push and pop in the same cycle are allowed.
  - Overflow is impossible by the issue rule; a pop when empty is a no-op.
- Reset mid-request: an in-flight response arriving after reset deasserts finds outstanding=0 and is ignored. The memory model must not return stale data after reset.

Decomposition:
- Shared define header with the existing control encodings: add `FETCH_RESET_PC (32'h0000_0000) and `INST_NOP (32'h0000_0013).
- Existing NPC op codes stay where they are.
- One sub-module: fetch_fifo.
  - Synchronous FIFO, width 64, depth FIFO_DEPTH.
  - Ports: clk, reset, flush, push, push_data, pop, head, count.
- The top level holds fetch_pc, req_pc, outstanding, discard, misalign and the issue/accept logic.

Test Plan:
- Reset, 1-cycle memory, inst_ready=1: requests at 0x0, 0x4, 0x8 on cycles 1, 3, 5. inst_pc/inst_data show 0x0/mem[0] on cycle 3, then 0x4/mem[1], in order.
- inst_ready=0: after 2 instructions, imem_req_valid stays 0 and count=2. Raising inst_ready drains 0x0, then 0x4, and fetch resumes at 0x8.
- Redirect to 0x100 while the request for 0x8 is outstanding: its response is dropped, FIFO is empty the next cycle, and the next request is 0x100 after that response returns. inst_pc=0x100 is the next delivered instruction.
- Redirect to 0x200 in the same cycle imem_rsp_valid returns the 0x4 instruction: 0x4 never appears on inst_*. A request for 0x200 issues the next cycle.
- Redirect to 0x102: misalign=1, no requests for 20 cycles. Redirect to 0x40: misalign=0 and the request for 0x40 issues.
- Reset asserted mid-stream with 1 entry buffered and 1 outstanding: inst_valid=0, and the first post-reset request is at RESET_PC. A late response is ignored.
